// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch bundle type and pipeline constants.
package cpu_pkg;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Small synchronous FIFO of fetch entries with flush and occupancy count.
module fetch_buf
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  fetch_entry                   wdata,
    output fetch_entry                   rdata,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry     mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic           full;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && !full;
    assign rdata   = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= wdata;
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst) !(push && full && !flush)
    );

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: PC owner, credit-limited imem requests, redirect squash.
// Optional perf counters are built when FETCH_PERF_CNT_EN is defined.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] out_PC,
    output logic [31:0] out_Instruction,
    output logic        out_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_bubble_cnt,
    output logic [31:0] perf_redirect_cnt
`endif
);

    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int TW = CW + 1;

    logic [31:0]   fetch_pc;
    logic [CW-1:0] drop;
    logic [CW-1:0] inflight;
    logic [CW-1:0] inflight_nx;
    logic [CW-1:0] buf_count;
    logic [TW-1:0] credit_used;

    fetch_entry    tag_wdata;
    fetch_entry    tag_head;
    fetch_entry    buf_wdata;
    fetch_entry    buf_head;
    logic          tag_empty;
    logic          buf_empty;

    logic          accept;
    logic          resp;
    logic          discard;
    logic          push;
    logic          pop;
    logic          unused_tag_instr;

    // A head leaving this cycle frees its slot for a new request.
    assign pop         = !buf_empty && !stall && !redirect_valid;
    assign credit_used = TW'(inflight) + TW'(buf_count) - TW'(pop);

    assign imem_req_valid = !rst && !redirect_valid
                          && (credit_used < TW'(BUF_DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign accept         = imem_req_valid && imem_req_ready;

    assign resp        = imem_resp_valid && !tag_empty;
    assign discard     = redirect_valid || (drop != '0);
    assign push        = resp && !discard;
    assign inflight_nx = inflight + CW'(accept) - CW'(resp);

    assign tag_wdata = '{pc: fetch_pc, instr: INSTR_NOP};
    assign buf_wdata = '{pc: tag_head.pc, instr: imem_resp_data};
    assign unused_tag_instr = ^tag_head.instr;

    // Tag queue occupancy is the in-flight request count.
    fetch_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_tag_q (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (resp),
        .flush (1'b0),
        .wdata (tag_wdata),
        .rdata (tag_head),
        .empty (tag_empty),
        .count (inflight)
    );

    fetch_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_fetch_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (buf_wdata),
        .rdata (buf_head),
        .empty (buf_empty),
        .count (buf_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            drop     <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= word_align(redirect_pc);
            drop     <= inflight_nx;
        end else begin
            if (accept)
                fetch_pc <= fetch_pc + PC_STEP;
            if (resp && (drop != '0))
                drop <= drop - CW'(1);
        end
    end

    assign out_valid       = !buf_empty;
    assign out_PC          = buf_empty ? 32'h0 : buf_head.pc;
    assign out_Instruction = buf_empty ? INSTR_NOP : buf_head.instr;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_bubble_cnt   <= '0;
            perf_redirect_cnt <= '0;
        end else begin
            if (!stall && buf_empty)
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            if (redirect_valid)
                perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
        end
    end
`endif

endmodule
